// File: rtl/charaan_adc_pkg.sv
// charaan_adc_pkg
// Shared constants for the 3-bit data converter path. Used by both the
// flash ADC thermometer-to-binary encoder and the DAC-side
// binary-to-thermometer decoder. Both sides therefore agree on code width
// and unit-element count.
//   N_BITS : binary code width
//   N_ELEM : number of unit elements (always 2**N_BITS)
package charaan_adc_pkg;

  localparam int N_BITS = 3;
  localparam int N_ELEM = 1 << N_BITS;

endpackage

// File: rtl/charaan_therm_rot.sv
// charaan_therm_rot
// Purely combinational rotated-thermometer generator. Exactly code+1
// elements are set. They start at element 'start' and wrap modulo N_ELEM.
// With start = 0 this gives the plain thermometer word.
// Ports:
//   code  : binary code k (0..N_ELEM-1)
//   start : index of the first enabled element
//   therm : unit-element enable word
module charaan_therm_rot
  import charaan_adc_pkg::*;
(
  input  logic [N_BITS-1:0] code,
  input  logic [N_BITS-1:0] start,
  output logic [N_ELEM-1:0] therm
);

  logic [N_BITS-1:0] offset;

  // Element i is enabled when its distance from 'start' (mod N_ELEM) is
  // at most k. The N_BITS-wide subtraction supplies the wrap for free.
  always_comb begin
    therm  = '0;
    offset = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      offset   = N_BITS'(i) - start;
      therm[i] = (offset <= code);
    end
  end

endmodule

// File: rtl/charaan_therm_dec.sv
// charaan_therm_dec
// Binary-to-thermometer decoder for a unit-element DAC. It has optional
// data-weighted averaging (DWA): when dem_en is set, each accepted code
// enables the next k+1 elements, starting at ptr, and ptr advances past
// them. One registered output stage carries backpressure.
// Ports:
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   code_in    : binary code k (0..7)
//   in_valid   : code_in valid
//   in_ready   : block can accept a code this cycle
//   dem_en     : 1 = DWA rotation, 0 = fixed mapping (sampled on accept)
//   therm_out  : unit-element enable word
//   out_valid  : therm_out valid
//   out_ready  : downstream consumes therm_out
//   ptr        : current DWA start pointer (debug)
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A producer holds valid (and data) stable until that edge. in_ready is
// a function of the output register and out_ready only, never of
// in_valid. A word held with out_valid=1 stays unchanged until it is
// consumed or reset.
module charaan_therm_dec
  import charaan_adc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] code_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              dem_en,
  output logic [N_ELEM-1:0] therm_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] ptr
);

  logic              accept;
  logic [N_BITS-1:0] rot_start;
  logic [N_ELEM-1:0] rot_word;

  // Register is free when it is empty, or when its word drains this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Fixed mode is the rotator anchored at element 0. ptr is left alone
  // so that DWA resumes where it stopped.
  assign rot_start = dem_en ? ptr : '0;

  charaan_therm_rot u_rot (
    .code  (code_in),
    .start (rot_start),
    .therm (rot_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      therm_out <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      therm_out <= rot_word;
      if (dem_en) begin
        // Advance past the k+1 elements just used. This wraps mod N_ELEM,
        // so k=7 returns ptr to itself.
        ptr <= ptr + code_in + N_BITS'(1);
      end
    end else if (out_ready) begin
      // Drained with no replacement. therm_out keeps its last value.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/charaan_therm_dec.md
Name: charaan_therm_dec

Overview:
- Binary-to-thermometer decoder for the 3-bit data converter path: the reverse of the flash ADC's thermometer-to-binary priority encoder.
- Accepts a 3-bit code over a valid/ready handshake and drives an 8-bit unit-element enable word for a unit-element DAC.
- Optional dynamic element matching (DEM): data-weighted averaging rotates which unit elements are used.
- One registered output stage with backpressure.

Parameters:
- N_BITS, 3, code width.
- N_ELEM, 8, number of unit elements; must equal 2**N_BITS.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- code_in  input  N_BITS  binary code k, range 0..7.
- in_valid  input  1  code_in is valid.
- in_ready  output  1  block can accept a code this cycle.
- dem_en  input  1  1 = DWA rotation, 0 = fixed mapping; sampled on accept.
- therm_out  output  N_ELEM  unit-element enable word.
- out_valid  output  1  therm_out is valid.
- out_ready  input  1  downstream consumes therm_out.
- ptr  output  N_BITS  current DWA start pointer (debug/verification).

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at a clk edge): out_valid=0, therm_out=0, ptr=0. Reset overrides all other activity, including mid-transfer. Reset while out_valid=1 discards the held word.
- in_ready = !out_valid || out_ready. This is combinational and has no dependence on in_valid.
- Accept: in_valid && in_ready at a clk edge.
- Latency: therm_out and out_valid are registered one cycle after accept. No bubble is added: accept and drain in the same cycle replaces the held word.
- No accept and out_ready=1: out_valid clears to 0 and therm_out holds its last value.
- Stall (out_valid=1, out_ready=0): therm_out, out_valid and ptr are held stable. in_ready=0, so in_valid is ignored.
- Code k asserts exactly k+1 elements. This matches the encoder convention: code 0 means only bit 0 is set; code 7 means all bits are set.
- Fixed mode (dem_en=0 at accept): therm_out[i] = (i <= k). ptr is unchanged; it is not cleared.
- DWA mode (dem_en=1 at accept): therm_out[(ptr+j) mod 8] = 1 for j = 0..k, all other bits 0. Then ptr <= (ptr + k + 1) mod 8.
- Pointer arithmetic is N_BITS-wide and wraps naturally. k=7 leaves ptr unchanged.
- Mode switch: dem_en affects only the accepted code. Switching from DWA to fixed and back resumes from the retained ptr.
- ptr is updated only on accept.
- code_in is always in range (3-bit). No error state.

Decomposition:
- Shared package `charaan_adc_pkg`: N_BITS=3 and N_ELEM=8 constants, shared with the ADC encoder path.
- Sub-module `charaan_therm_rot`: purely combinational; inputs code k and start pointer, output the rotated thermometer word.
- Top level holds the handshake register, ptr register and mode selection. The fixed mode reuses the rotator with pointer 0.

Test Plan:
1. Hold rst=1 for 2 cycles, then release -> out_valid=0, therm_out=8'h00, ptr=0, in_ready=1.
2. dem_en=0, out_ready=1, back-to-back codes 0, 3, 7 -> therm_out 8'h01, 8'h0F, 8'hFF on consecutive cycles, each one cycle after its accept; ptr stays 0.
3. dem_en=1, starting ptr=0, codes 2, 3, 4 -> therm_out 8'h07 (ptr->3), then 8'h78 (ptr->7), then 8'h8F (ptr->4).
4. Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=1 and code 5 -> in_ready=0; therm_out and ptr unchanged. Release out_ready -> code 5 accepted that cycle; result appears the next cycle.
5. dem_en=1, ptr=5, code 7 -> therm_out=8'hFF, ptr stays 5. Then code 0 -> therm_out=8'h20, ptr->6.
6. rst asserted for 1 cycle while out_valid=1 and ptr=3 -> next cycle out_valid=0, therm_out=8'h00, ptr=0. A following code 1 with dem_en=1 -> therm_out=8'h03.
